// File: rtl/video_in_write.sv
// Write-side video DMA: packs FIFO pixels four per word and burst-writes one
// frame to RAM over a Wishbone master, then pulses an end-of-frame interrupt.
module video_in_write #(
    parameter int P_WIDTH  = 640,
    parameter int P_HEIGHT = 480,
    parameter int NBPACK   = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    output logic        interrupt,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_WE_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic        empty,
    output logic        r_e,
    input  logic [7:0]  pixel_in
);
    localparam int NWORDS = NBPACK / 4;
    localparam int WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PCW    = WIW + 2;
    localparam logic [19:0]    FRAME_PIX = 20'(P_WIDTH * P_HEIGHT);
    localparam logic [19:0]    PACK_PIX  = 20'(NBPACK);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(NWORDS - 1);
    localparam logic [PCW-1:0] LAST_SLOT = PCW'(NBPACK - 1);

    typedef enum logic [2:0] {
        S_WAIT_ADDR, S_FILL, S_WRITE_RAM, S_BREAK, S_IMAGE_PROCESSED
    } state_t;

    state_t                   r_state;
    logic                     r_ctr0_d;
    logic [31:0]              r_base;
    logic [19:0]              r_pixel_cnt;
    logic [PCW-1:0]           r_pack_cnt;
    logic [WIW-1:0]           r_word_idx;
    logic [1:0]               r_irq_cnt;
    logic [NWORDS-1:0][31:0]  r_pack;

    logic        w_start;
    logic        w_pop;
    logic        w_stb;
    logic [19:0] w_pix_next;
    logic        w_unused_bits;

    assign w_start       = ~r_ctr0_d & wb_reg_ctr[0];
    assign w_pop         = (r_state == S_FILL) & ~empty;
    assign w_stb         = (r_state == S_WRITE_RAM);
    assign w_pix_next    = r_pixel_cnt + PACK_PIX;
    assign w_unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_WAIT_ADDR;
            r_ctr0_d    <= 1'b1;
            r_base      <= '0;
            r_pixel_cnt <= '0;
            r_pack_cnt  <= '0;
            r_word_idx  <= '0;
            r_irq_cnt   <= '0;
            r_pack      <= '0;
        end else begin
            r_ctr0_d <= wb_reg_ctr[0];
            case (r_state)
                S_WAIT_ADDR: begin
                    if (w_start) begin
                        r_base  <= {wb_reg_data[31:2], 2'b00};
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_pop) begin
                        // first pixel of each word lands in the top byte
                        r_pack[r_pack_cnt[PCW-1:2]][{~r_pack_cnt[1:0], 3'b000} +: 8] <= pixel_in;
                        r_pack_cnt <= r_pack_cnt + 1'b1;
                        if (r_pack_cnt == LAST_SLOT) begin
                            r_word_idx <= '0;
                            r_state    <= S_WRITE_RAM;
                        end
                    end
                end
                S_WRITE_RAM: begin
                    if (p_wb_ACK_I) r_state <= S_BREAK;
                end
                S_BREAK: begin
                    if (r_word_idx != LAST_WORD) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_state    <= S_WRITE_RAM;
                    end else begin
                        r_pixel_cnt <= w_pix_next;
                        r_pack_cnt  <= '0;
                        r_state     <= (w_pix_next == FRAME_PIX) ? S_IMAGE_PROCESSED : S_FILL;
                    end
                end
                S_IMAGE_PROCESSED: begin
                    r_irq_cnt <= r_irq_cnt + 2'd1;
                    if (r_irq_cnt == 2'd3) begin
                        r_pixel_cnt <= '0;
                        r_state     <= S_WAIT_ADDR;
                    end
                end
                default: r_state <= S_WAIT_ADDR;
            endcase
        end
    end

    // Bus outputs decode straight from the state register so reset drops them at once.
    assign p_wb_STB_O  = w_stb;
    assign p_wb_CYC_O  = w_stb;
    assign p_wb_WE_O   = w_stb;
    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_SEL_O  = 4'hf;
    assign p_wb_ADR_O  = w_stb ? (r_base + {12'b0, r_pixel_cnt} + {{(30-WIW){1'b0}}, r_word_idx, 2'b00})
                               : 32'h0;
    assign p_wb_DAT_O  = w_stb ? r_pack[r_word_idx] : 32'h0;
    assign interrupt   = (r_state == S_IMAGE_PROCESSED);
    assign r_e         = w_pop;
endmodule

// File: tb/tb_video_in_write.sv
// Directed bench for video_in_write: frame table plus hand sequences for
// retrigger, level-at-reset and mid-frame reset behaviour.
module tb_video_in_write;
    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] wb_reg_data, wb_reg_ctr;
    logic        interrupt;
    logic [31:0] p_wb_DAT_O, p_wb_ADR_O;
    logic        p_wb_ACK_I, p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic        empty, r_e;
    logic [7:0]  pixel_in;

    video_in_write #(.P_WIDTH(16), .P_HEIGHT(2), .NBPACK(16)) dut (
        .clk(clk), .nRST(nRST), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
        .interrupt(interrupt), .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ACK_I(p_wb_ACK_I),
        .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_LOCK_O(p_wb_LOCK_O),
        .p_wb_SEL_O(p_wb_SEL_O), .p_wb_WE_O(p_wb_WE_O), .p_wb_ADR_O(p_wb_ADR_O),
        .empty(empty), .r_e(r_e), .pixel_in(pixel_in)
    );

    always #5 clk = ~clk;

    // model configuration (written by the test process)
    int         ack_dly = 1, starve_at = 0, starve_len = 0;
    bit         spur_ack = 0, clr = 0;
    logic [7:0] pix0 = 8'h00;

    // model state and statistics (written by the model process)
    int          idx, gap, pops, irq_cnt, stbcyc, low_run, cyc;
    int          stab_viol, gap_viol, re_viol;
    bit          pop_pending;
    logic [31:0] hold_adr, hold_dat;
    logic [31:0] wadr[$], wdat[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // FIFO + Wishbone slave model: sample at negedge, update FIFO after posedge
    initial begin
        p_wb_ACK_I = 0; empty = 0; pixel_in = 0;
        idx = 0; gap = 0; pops = 0; irq_cnt = 0; stbcyc = 0; low_run = 0; cyc = 0;
        stab_viol = 0; gap_viol = 0; re_viol = 0; pop_pending = 0;
        forever begin
            @(negedge clk);
            if (p_wb_WE_O !== p_wb_STB_O || p_wb_CYC_O !== p_wb_STB_O) stab_viol++;
            if (r_e && (empty || p_wb_STB_O)) re_viol++;
            if (interrupt) irq_cnt++;
            pop_pending = r_e;
            if (r_e) pops++;
            if (p_wb_STB_O) begin
                stbcyc++;
                if (stbcyc == 1) begin
                    if (wadr.size() > 0 && wadr.size() % 4 != 0 && low_run != 1) gap_viol++;
                    low_run = 0; hold_adr = p_wb_ADR_O; hold_dat = p_wb_DAT_O;
                end else if (p_wb_ADR_O !== hold_adr || p_wb_DAT_O !== hold_dat) stab_viol++;
                p_wb_ACK_I = (stbcyc == ack_dly + 1);
                if (p_wb_ACK_I) begin
                    wadr.push_back(p_wb_ADR_O);
                    wdat.push_back(p_wb_DAT_O);
                end
            end else begin
                stbcyc = 0; low_run++;
                p_wb_ACK_I = spur_ack && cyc[0];
            end
            @(posedge clk); #1;
            cyc++;
            if (clr) begin
                idx = 0; gap = 0; pops = 0; irq_cnt = 0; low_run = 0; pop_pending = 0;
                stab_viol = 0; gap_viol = 0; re_viol = 0;
                wadr.delete(); wdat.delete();
            end else if (pop_pending) idx++;
            if (starve_len > 0 && idx == starve_at && gap < starve_len) begin
                empty = 1; gap++;
            end else empty = 0;
            pixel_in = pix0 + idx[7:0];
        end
    end

    typedef struct {
        logic [31:0] base;
        int          dly, s_at, s_len;
        logic [7:0]  p0;
        bit          spur_start, sack;
        logic [31:0] adr0, dat0, adr4, dat4, adr7, dat7;
    } vec_t;
    vec_t vecs[5];

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_clr;
        clr = 1; cycles(1); clr = 0;
    endtask

    task automatic start_frame(input logic [31:0] base);
        wb_reg_data = base; wb_reg_ctr = 0; cycles(1); wb_reg_ctr = 1;
    endtask

    task automatic wait_frame(input string nm);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            cycles(1);
            if (irq_cnt >= 4 && !interrupt) done = 1;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        cycles(3);
    endtask

    function automatic logic [31:0] qget(input int which, input int i);
        if (which == 0) return (wadr.size() > i) ? wadr[i] : 32'hDEADBEEF;
        return (wdat.size() > i) ? wdat[i] : 32'hDEADBEEF;
    endfunction

    initial begin
        vecs[0] = '{32'h1000_0003, 1, 0, 0, 8'h00, 0, 0,
                    32'h1000_0000, 32'h0001_0203, 32'h1000_0010, 32'h1011_1213, 32'h1000_001C, 32'h1C1D_1E1F};
        vecs[1] = '{32'h1000_0003, 1, 7, 5, 8'h00, 0, 0,
                    32'h1000_0000, 32'h0001_0203, 32'h1000_0010, 32'h1011_1213, 32'h1000_001C, 32'h1C1D_1E1F};
        vecs[2] = '{32'h1000_0000, 6, 0, 0, 8'h40, 0, 0,
                    32'h1000_0000, 32'h4041_4243, 32'h1000_0010, 32'h5051_5253, 32'h1000_001C, 32'h5C5D_5E5F};
        vecs[3] = '{32'h1000_0040, 1, 0, 0, 8'h80, 1, 1,
                    32'h1000_0040, 32'h8081_8283, 32'h1000_0050, 32'h9091_9293, 32'h1000_005C, 32'h9C9D_9E9F};
        vecs[4] = '{32'hFFFF_FFF2, 2, 0, 0, 8'hF0, 0, 0,
                    32'hFFFF_FFF0, 32'hF0F1_F2F3, 32'h0000_0000, 32'h0001_0203, 32'h0000_000C, 32'h0C0D_0E0F};

        nRST = 0; wb_reg_data = 0; wb_reg_ctr = 32'h1;
        #1;
        chk("rst_ctl", {26'b0, interrupt, p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, r_e, p_wb_LOCK_O}, 32'h0);
        chk("rst_sel", {28'b0, p_wb_SEL_O}, 32'hf);
        chk("rst_adr", p_wb_ADR_O, 32'h0);
        chk("rst_dat", p_wb_DAT_O, 32'h0);
        cycles(3);
        nRST = 1;
        do_clr();
        // ctr0 already high at reset release must not start a frame
        cycles(20);
        chk("lvl_pops", 32'(pops), 32'd0);
        chk("lvl_wr", 32'(wadr.size()), 32'd0);

        for (int v = 0; v < 5; v++) begin
            int bad;
            ack_dly = vecs[v].dly; starve_at = vecs[v].s_at; starve_len = vecs[v].s_len;
            pix0 = vecs[v].p0; spur_ack = vecs[v].sack;
            do_clr();
            start_frame(vecs[v].base);
            if (vecs[v].spur_start) begin
                cycles(10);
                wb_reg_data = 32'h2000_0000; wb_reg_ctr = 0;
                cycles(1);
                wb_reg_ctr = 1;
            end
            wait_frame($sformatf("v%0d", v));
            chk($sformatf("v%0d_nwr", v), 32'(wadr.size()), 32'd8);
            chk($sformatf("v%0d_adr0", v), qget(0, 0), vecs[v].adr0);
            chk($sformatf("v%0d_dat0", v), qget(1, 0), vecs[v].dat0);
            chk($sformatf("v%0d_adr4", v), qget(0, 4), vecs[v].adr4);
            chk($sformatf("v%0d_dat4", v), qget(1, 4), vecs[v].dat4);
            chk($sformatf("v%0d_adr7", v), qget(0, 7), vecs[v].adr7);
            chk($sformatf("v%0d_dat7", v), qget(1, 7), vecs[v].dat7);
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                logic [31:0] pb;
                pb = vecs[v].p0 + 8'(4 * i);
                if (qget(0, i) !== vecs[v].adr0 + 32'(4 * i)) bad++;
                if (qget(1, i) !== {pb[7:0], pb[7:0] + 8'd1, pb[7:0] + 8'd2, pb[7:0] + 8'd3}) bad++;
            end
            chk($sformatf("v%0d_seq", v), 32'(bad), 32'd0);
            chk($sformatf("v%0d_pops", v), 32'(pops), 32'd32);
            chk($sformatf("v%0d_irq", v), 32'(irq_cnt), 32'd4);
            chk($sformatf("v%0d_stab", v), 32'(stab_viol), 32'd0);
            chk($sformatf("v%0d_gap", v), 32'(gap_viol), 32'd0);
            chk($sformatf("v%0d_re", v), 32'(re_viol), 32'd0);
        end

        // ctr0 still high after the last frame: no retrigger
        spur_ack = 0; starve_len = 0; ack_dly = 6; pix0 = 8'hA0;
        do_clr();
        wb_reg_data = 32'h3000_0001;
        cycles(30);
        chk("hold_nwr", 32'(wadr.size()), 32'd0);
        chk("hold_pops", 32'(pops), 32'd0);

        // fresh edge starts at new base; reset while a write is in flight
        start_frame(32'h3000_0001);
        begin
            bit seen = 0;
            for (int c = 0; c < 500 && !seen; c++) begin
                cycles(1);
                if (p_wb_STB_O) seen = 1;
            end
            chk("mid_stb_seen", 32'(seen), 32'd1);
        end
        chk("mid_adr", p_wb_ADR_O, 32'h3000_0000);
        chk("mid_dat", p_wb_DAT_O, 32'hA0A1_A2A3);
        nRST = 0;
        #1;
        chk("mid_rst_ctl", {28'b0, interrupt, p_wb_STB_O, p_wb_CYC_O, r_e}, 32'h0);
        cycles(2);
        nRST = 1;
        ack_dly = 1;
        do_clr();
        start_frame(32'h3000_0000);
        wait_frame("post_rst");
        chk("post_nwr", 32'(wadr.size()), 32'd8);
        chk("post_adr0", qget(0, 0), 32'h3000_0000);
        chk("post_dat0", qget(1, 0), 32'hA0A1_A2A3);
        chk("post_irq", 32'(irq_cnt), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
